// File: rtl/fen_board_parser.sv
// Parses the piece-placement field of a FEN byte stream into 64 four-bit square codes
// (a8..h1), flagging malformed fields and resynchronising on the next start-of-string byte.
module fen_board_parser #(
   parameter int unsigned STRICT_TAIL = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   input  logic       in_sop,
   output logic       in_ready,
   output logic       out_pos_valid,
   output logic [3:0] out_pos_data,
   output logic       out_pos_sop,
   output logic       out_pos_eop,
   output logic       out_err
);

   typedef enum logic [1:0] {StIdle, StBoard, StTail, StSkip} state_e;

   localparam state_e DoneState = (STRICT_TAIL != 0) ? StTail : StSkip;

   state_e     state_q, state_d;
   logic [5:0] sq_q, sq_d;
   logic [3:0] file_q, file_d;
   logic [2:0] run_q, run_d;
   logic       valid_d, sop_d, eop_d, err_d;
   logic [3:0] data_d;

   logic       accept;
   logic       piece_ok, is_digit, is_slash;
   logic [3:0] piece_code;
   logic       do_byte, start;
   logic [5:0] cur_sq;
   logic [3:0] cur_file;
   logic [4:0] file_sum;

   assign in_ready = (state_q != StBoard) || (run_q == 3'd0);
   assign accept   = in_valid && in_ready;
   assign is_digit = (in_data >= "1") && (in_data <= "8");
   assign is_slash = (in_data == "/");

   always_comb begin
      piece_ok   = 1'b1;
      piece_code = 4'h0;
      case (in_data)
         "P": piece_code = 4'h1;
         "N": piece_code = 4'h2;
         "B": piece_code = 4'h3;
         "R": piece_code = 4'h4;
         "Q": piece_code = 4'h5;
         "K": piece_code = 4'h6;
         "p": piece_code = 4'h9;
         "n": piece_code = 4'hA;
         "b": piece_code = 4'hB;
         "r": piece_code = 4'hC;
         "q": piece_code = 4'hD;
         "k": piece_code = 4'hE;
         default: piece_ok = 1'b0;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      sq_d     = sq_q;
      file_d   = file_q;
      run_d    = run_q;
      valid_d  = 1'b0;
      data_d   = 4'h0;
      sop_d    = 1'b0;
      eop_d    = 1'b0;
      err_d    = 1'b0;
      do_byte  = 1'b0;
      start    = 1'b0;
      cur_sq   = sq_q;
      cur_file = file_q;
      file_sum = 5'd0;

      unique case (state_q)
         StIdle, StSkip: begin
            if (accept && in_sop) begin
               do_byte = 1'b1;
               start   = 1'b1;
            end
         end
         StTail: begin
            if (accept) begin
               if (in_sop) begin
                  err_d   = 1'b1;
                  do_byte = 1'b1;
                  start   = 1'b1;
               end else begin
                  err_d   = (in_data != 8'h20);
                  state_d = StSkip;
               end
            end
         end
         StBoard: begin
            if (run_q != 3'd0) begin
               // Remaining empties of a digit run; bytes are stalled meanwhile.
               valid_d = 1'b1;
               eop_d   = (sq_q == 6'd63);
               run_d   = run_q - 3'd1;
               sq_d    = sq_q + 6'd1;
               if (sq_q == 6'd63) begin
                  state_d = DoneState;
                  sq_d    = 6'd0;
                  file_d  = 4'd0;
               end
            end else if (accept) begin
               do_byte = 1'b1;
               if (in_sop) begin
                  err_d = 1'b1;
                  start = 1'b1;
               end
            end
         end
         default: ;
      endcase

      if (do_byte) begin
         if (start) begin
            cur_sq   = 6'd0;
            cur_file = 4'd0;
         end
         state_d  = StBoard;
         file_sum = {1'b0, cur_file} + {1'b0, in_data[3:0]};
         if (piece_ok && (cur_file < 4'd8)) begin
            valid_d = 1'b1;
            data_d  = piece_code;
            sop_d   = (cur_sq == 6'd0);
            eop_d   = (cur_sq == 6'd63);
            sq_d    = cur_sq + 6'd1;
            file_d  = cur_file + 4'd1;
            run_d   = 3'd0;
         end else if (is_digit && (file_sum <= 5'd8)) begin
            // Low three bits of '1'..'8' minus one give the remaining run length 0..7.
            valid_d = 1'b1;
            sop_d   = (cur_sq == 6'd0);
            eop_d   = (cur_sq == 6'd63);
            sq_d    = cur_sq + 6'd1;
            file_d  = file_sum[3:0];
            run_d   = in_data[2:0] - 3'd1;
         end else if (is_slash && (cur_file == 4'd8)) begin
            sq_d   = cur_sq;
            file_d = 4'd0;
            run_d  = 3'd0;
         end else begin
            err_d   = 1'b1;
            valid_d = 1'b0;
            sop_d   = 1'b0;
            eop_d   = 1'b0;
            state_d = StSkip;
            sq_d    = 6'd0;
            file_d  = 4'd0;
            run_d   = 3'd0;
         end
         if (valid_d && (cur_sq == 6'd63) && (run_d == 3'd0)) begin
            state_d = DoneState;
            sq_d    = 6'd0;
            file_d  = 4'd0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= StIdle;
         sq_q          <= 6'd0;
         file_q        <= 4'd0;
         run_q         <= 3'd0;
         out_pos_valid <= 1'b0;
         out_pos_data  <= 4'h0;
         out_pos_sop   <= 1'b0;
         out_pos_eop   <= 1'b0;
         out_err       <= 1'b0;
      end else begin
         state_q       <= state_d;
         sq_q          <= sq_d;
         file_q        <= file_d;
         run_q         <= run_d;
         out_pos_valid <= valid_d;
         out_pos_data  <= data_d;
         out_pos_sop   <= sop_d;
         out_pos_eop   <= eop_d;
         out_err       <= err_d;
      end
   end

endmodule

// File: tb/tb_fen_board_parser.sv
// Bench for fen_board_parser: strict and lenient instances share one byte stream and are
// checked every cycle against a square-list FEN model, plus literal checks per directed case.
module tb_fen_board_parser;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid, in_sop;
   logic [7:0] in_data;
   logic       rdy_s, v_s, sop_s, eop_s, err_s;
   logic       rdy_l, v_l, sop_l, eop_l, err_l;
   logic [3:0] d_s, d_l;

   always #5 clk = ~clk;

   fen_board_parser #(.STRICT_TAIL(1)) dut_s (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_sop(in_sop),
      .in_ready(rdy_s), .out_pos_valid(v_s), .out_pos_data(d_s), .out_pos_sop(sop_s),
      .out_pos_eop(eop_s), .out_err(err_s)
   );

   fen_board_parser #(.STRICT_TAIL(0)) dut_l (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_sop(in_sop),
      .in_ready(rdy_l), .out_pos_valid(v_l), .out_pos_data(d_l), .out_pos_sop(sop_l),
      .out_pos_eop(eop_l), .out_err(err_l)
   );

   typedef struct packed {
      logic       v;
      logic [3:0] d;
      logic       sop;
      logic       eop;
      logic       err;
   } rec_t;

   rec_t       pend_s[$], pend_l[$];
   rec_t       exp_s, exp_l;
   rec_t       tmp[8];
   int         ntmp;
   int         mmode[2], msq[2], mfile[2];  // mode: 0 idle, 1 board, 2 tail, 3 skip
   logic [7:0] stim_b[$];
   bit         stim_sop[$];
   bit         gaps, rst_trig;
   int         checks, errors;

   logic [3:0] cap_d[$];
   int         cap_sop_n, cap_sop_idx, cap_eop_n, cap_eop_idx, ne_s, ne_l, nrdy;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic rec_t mk(logic v, logic [3:0] d, logic s, logic e, logic r);
      rec_t x;
      x.v = v; x.d = d; x.sop = s; x.eop = e; x.err = r;
      return x;
   endfunction

   function automatic int piece_of(logic [7:0] b);
      string pc = "PNBRQK";
      for (int i = 0; i < 6; i++) begin
         if (b == pc[i]) return i + 1;
         if (b == pc[i] + 8'd32) return 9 + i;
      end
      return 0;
   endfunction

   // One accepted byte: appends the output cycles it causes to tmp[0..ntmp-1].
   function automatic void model_byte(int m, logic [7:0] b, logic sop);
      bit errf = 0;
      bit start = 0;
      int code, d;
      ntmp = 0;
      case (mmode[m])
         1: begin
            if (sop) begin errf = 1; start = 1; end
         end
         2: begin
            if (sop) begin
               errf = 1; start = 1;
            end else begin
               mmode[m] = 3;
               if (b != 8'h20) begin tmp[0] = mk(0, 0, 0, 0, 1); ntmp = 1; end
               return;
            end
         end
         default: begin
            if (!sop) return;
            start = 1;
         end
      endcase
      if (start) begin msq[m] = 0; mfile[m] = 0; mmode[m] = 1; end
      code = piece_of(b);
      d = (b >= 8'h31 && b <= 8'h38) ? int'(b) - 48 : 0;
      if (code != 0 && mfile[m] < 8) begin
         tmp[ntmp++] = mk(1, 4'(code), msq[m] == 0, msq[m] == 63, errf);
         msq[m]++;
         mfile[m]++;
      end else if (d != 0 && mfile[m] + d <= 8) begin
         for (int i = 0; i < d; i++) begin
            tmp[ntmp++] = mk(1, 0, msq[m] == 0, msq[m] == 63, (i == 0) && errf);
            msq[m]++;
         end
         mfile[m] += d;
      end else if (b == 8'h2F && mfile[m] == 8) begin
         mfile[m] = 0;
      end else begin
         tmp[ntmp++] = mk(0, 0, 0, 0, 1);
         mmode[m] = 3;
      end
      if (msq[m] == 64) mmode[m] = (m == 0) ? 2 : 3;
   endfunction

   task automatic model_reset();
      pend_s.delete();
      pend_l.delete();
      for (int m = 0; m < 2; m++) begin mmode[m] = 0; msq[m] = 0; mfile[m] = 0; end
      exp_s = '0;
      exp_l = '0;
   endtask

   task automatic clear_cap();
      cap_d.delete();
      cap_sop_n = 0; cap_sop_idx = -1; cap_eop_n = 0; cap_eop_idx = -1;
      ne_s = 0; ne_l = 0; nrdy = 0;
   endtask

   task automatic push_str(string s, bit sop_first);
      for (int i = 0; i < s.len(); i++) begin
         stim_b.push_back(s[i]);
         stim_sop.push_back(sop_first && (i == 0));
      end
   endtask

   task automatic cycle();
      logic acc;
      @(negedge clk);
      chk("valid_s", v_s, exp_s.v);
      chk("sop_s", sop_s, exp_s.sop);
      chk("eop_s", eop_s, exp_s.eop);
      chk("err_s", err_s, exp_s.err);
      if (exp_s.v) chk("data_s", d_s, exp_s.d);
      chk("valid_l", v_l, exp_l.v);
      chk("sop_l", sop_l, exp_l.sop);
      chk("eop_l", eop_l, exp_l.eop);
      chk("err_l", err_l, exp_l.err);
      if (exp_l.v) chk("data_l", d_l, exp_l.d);
      chk("ready_s", rdy_s, pend_s.size() == 0);
      chk("ready_l", rdy_l, pend_l.size() == 0);
      if (v_s) begin
         cap_d.push_back(d_s);
         if (sop_s) begin cap_sop_n++; cap_sop_idx = cap_d.size() - 1; end
         if (eop_s) begin cap_eop_n++; cap_eop_idx = cap_d.size() - 1; end
      end
      if (err_s) ne_s++;
      if (err_l) ne_l++;
      if (!rdy_s) nrdy++;
      if (rst_trig && pend_s.size() == 5) begin
         rst = 1'b1;
         #1;
         chk("rst_valid_s", v_s, 0);
         chk("rst_valid_l", v_l, 0);
         rst = 1'b0;
         #1;
         chk("rst_ready_s", rdy_s, 1);
         chk("rst_ready_l", rdy_l, 1);
         model_reset();
         clear_cap();
         rst_trig = 1'b0;
      end
      if (stim_b.size() != 0 && (!gaps || $urandom_range(0, 3) != 0)) begin
         in_valid = 1'b1;
         in_data  = stim_b[0];
         in_sop   = stim_sop[0];
      end else begin
         in_valid = 1'b0;
         in_data  = 8'($urandom);
         in_sop   = 1'($urandom);
      end
      acc = in_valid && (pend_s.size() == 0);
      if (acc) begin
         stim_b.delete(0);
         stim_sop.delete(0);
         model_byte(0, in_data, in_sop);
         for (int i = 0; i < ntmp; i++) pend_s.push_back(tmp[i]);
         model_byte(1, in_data, in_sop);
         for (int i = 0; i < ntmp; i++) pend_l.push_back(tmp[i]);
      end
      exp_s = (pend_s.size() != 0) ? pend_s.pop_front() : '0;
      exp_l = (pend_l.size() != 0) ? pend_l.pop_front() : '0;
   endtask

   task automatic run_stream(bit use_gaps);
      int cyc = 0;
      gaps = use_gaps;
      while ((stim_b.size() != 0 || pend_s.size() != 0 || pend_l.size() != 0) && cyc < 20000) begin
         cycle();
         cyc++;
      end
      if (cyc >= 20000) chk("stream_timeout", cyc, 0);
      repeat (3) cycle();
   endtask

   task automatic gen_random_string();
      logic [7:0] pl[$];
      string pc = "PNBRQKpnbrqk";
      string cs = "0912/ pkQxZ";
      int e, kind, idx;
      for (int r = 0; r < 8; r++) begin
         e = 0;
         for (int f = 0; f < 8; f++) begin
            if ($urandom_range(0, 1) != 0) e++;
            else begin
               if (e != 0) pl.push_back(8'(48 + e));
               e = 0;
               pl.push_back(pc[$urandom_range(0, 11)]);
            end
         end
         if (e != 0) pl.push_back(8'(48 + e));
         if (r < 7) pl.push_back(8'h2F);
      end
      kind = $urandom_range(0, 9);
      if (kind <= 2) begin
         idx = $urandom_range(0, pl.size() - 1);
         pl[idx] = cs[$urandom_range(0, cs.len() - 1)];
      end
      if (kind == 3 || kind == 4) begin
         idx = $urandom_range(1, pl.size() - 1);
         while (pl.size() > idx) pl.delete(pl.size() - 1);
      end
      for (int i = 0; i < pl.size(); i++) begin
         stim_b.push_back(pl[i]);
         stim_sop.push_back(i == 0);
      end
      if (kind == 5) push_str("w KQkq", 0);
      else if (kind != 3 && kind != 4) begin
         push_str(" w - - 0 1", 0);
         for (int i = 0; i < $urandom_range(0, 3); i++) begin
            stim_b.push_back(8'($urandom));
            stim_sop.push_back(1'b0);
         end
      end
   endtask

   initial begin
      int nz;
      checks = 0; errors = 0; rst_trig = 1'b0; gaps = 1'b0;
      rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_sop = 1'b0;
      model_reset();
      clear_cap();
      repeat (2) @(negedge clk);
      chk("reset_valid", v_s, 0);
      chk("reset_sop", sop_s, 0);
      chk("reset_eop", eop_s, 0);
      chk("reset_err", err_s, 0);
      chk("reset_data", d_s, 0);
      rst = 1'b0;
      #1;
      chk("reset_ready", rdy_s, 1);

      // Start position
      clear_cap();
      push_str("rnbqkbnr/pppppppp/8/8/8/8/PPPPPPPP/RNBQKBNR w KQkq - 0 1", 1);
      run_stream(0);
      nz = 0;
      for (int i = 16; i < 48; i++) if (cap_d[i] != 4'h0) nz++;
      chk("start_count", cap_d.size(), 64);
      chk("start_sq0", cap_d[0], 4'hC);
      chk("start_sop_idx", cap_sop_idx, 0);
      chk("start_sop_n", cap_sop_n, 1);
      chk("start_empty_16_47", nz, 0);
      chk("start_sq60", cap_d[60], 4'h6);
      chk("start_sq63", cap_d[63], 4'h4);
      chk("start_eop_idx", cap_eop_idx, 63);
      chk("start_err_s", ne_s, 0);
      chk("start_err_l", ne_l, 0);

      // All-digit board with in_valid held high: each '8' stalls for 7 cycles
      clear_cap();
      push_str("8/8/8/8/8/8/8/8 w", 1);
      run_stream(0);
      chk("empty_count", cap_d.size(), 64);
      chk("empty_nrdy", nrdy, 56);
      chk("empty_eop_idx", cap_eop_idx, 63);
      chk("empty_err", ne_s, 0);

      // Short rank
      clear_cap();
      push_str("rnbqkbnr/ppppppp/8/8/8/8/PPPPPPPP/RNBQKBNR w", 1);
      run_stream(1);
      chk("short_count", cap_d.size(), 15);
      chk("short_eop_n", cap_eop_n, 0);
      chk("short_err", ne_s, 1);

      clear_cap();
      push_str("r9/8/8/8/8/8/8/8 w", 1);
      run_stream(1);
      chk("nine_count", cap_d.size(), 1);
      chk("nine_err", ne_s, 1);

      clear_cap();
      push_str("4p4/8/8/8/8/8/8/8 w", 1);
      run_stream(1);
      chk("ovf_count", cap_d.size(), 5);
      chk("ovf_err", ne_s, 1);

      // New sop after 20 squares
      clear_cap();
      push_str("rnbqkbnr/pppppppp/4", 1);
      push_str("rnbqkbnr/pppppppp/8/8/8/8/PPPPPPPP/RNBQKBNR w - - 0 1", 1);
      run_stream(0);
      chk("resop_count", cap_d.size(), 84);
      chk("resop_sop_n", cap_sop_n, 2);
      chk("resop_sop_idx", cap_sop_idx, 20);
      chk("resop_eop_idx", cap_eop_idx, 83);
      chk("resop_err", ne_s, 1);

      // Tail byte not a space
      clear_cap();
      push_str("rnbqkbnr/pppppppp/8/8/8/8/PPPPPPPP/RNBQKBNRw KQkq", 1);
      run_stream(1);
      chk("tail_count", cap_d.size(), 64);
      chk("tail_eop_idx", cap_eop_idx, 63);
      chk("tail_err_strict", ne_s, 1);
      chk("tail_err_lenient", ne_l, 0);

      // Reset during a six-square run (run=5), then sop-less bytes are ignored
      clear_cap();
      rst_trig = 1'b1;
      push_str("rnbqkbnr/pppppppp/6", 1);
      push_str("2/8/8/8/PPPPPPPP/RNBQKBNR w", 0);
      run_stream(0);
      chk("rst_fired", rst_trig, 0);
      chk("rst_count", cap_d.size(), 0);
      chk("rst_err", ne_s + ne_l, 0);

      for (int n = 0; n < 40; n++) gen_random_string();
      run_stream(1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
